// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: synchronises and debounces a raw push-button level and emits a
//   single-cycle toggle pulse on t_out for each accepted press (no pulse on release).
// Latency: t_out is high the cycle after edge E(SYNC_STAGES+DEBOUNCE_CYCLES-1), where E0
//   is the first edge that samples btn_in high. No backpressure: t_out is a pure pulse.
// Ports: clk (system clock), reset (synchronous, active-low), btn_in (raw async level),
//   t_out (registered one-cycle toggle pulse), btn_level (registered debounced level).
// Optional macro AUTO_REPEAT_EN: while the button stays pressed, an extra pulse is emitted
//   every REPEAT_CYCLES cycles after the initial one. Undefined: one pulse per press.
module toggle_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic t_out,
  output logic btn_level
);

  // Elaboration-time sanity check on the parameter set.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 ||
      (DEBOUNCE_CYCLES - 1) >= (2 ** CNT_W) || (REPEAT_CYCLES - 1) >= (2 ** CNT_W)) begin : g_param_check
    $error("toggle_pulse_gen: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   t_d;
  logic                   level_d;

  // Synchroniser chain; only the last stage is ever looked at by the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      t_out     <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_out     <= t_d;
      btn_level <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    level_d = btn_level;
`ifdef AUTO_REPEAT_EN
    rcnt_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          // Bounce during the press window: drop back without a pulse.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          t_d     = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rcnt_q == REP_LAST) begin
            t_d    = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + CNT_ONE;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          // Release bounce: button is still held, no new pulse and the
          // repeat period starts over.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// tb_toggle_pulse_gen: scoreboard bench for toggle_pulse_gen. A behavioural debounce
//   model predicts t_out/btn_level for every edge; predictions are queued when the
//   stimulus is driven and compared after the edge.
module tb_toggle_pulse_gen;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int REP  = 16;

`ifdef AUTO_REPEAT_EN
  localparam int EXP_REL_PULSES = 1;
  localparam int EXP_Q1         = 0;
  localparam int EXP_HOLD100    = 6;
`else
  localparam int EXP_REL_PULSES = 0;
  localparam int EXP_Q1         = 1;
  localparam int EXP_HOLD100    = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic t_out;
  logic btn_level;

  always #5 clk = ~clk;

  toggle_pulse_gen #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES(REP),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .t_out(t_out),
    .btn_level(btn_level)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: tracks the run length of identical synchronised samples;
  // the debounced level flips once a run of the opposite value reaches DEB.
  logic [SYNC-1:0] m_sync = '0;
  logic            m_run_val = 1'b0;
  int              m_run_len = 0;
  logic            m_level = 1'b0;
  int              m_rep = 0;

  logic [1:0] exp_q[$];

  int   idx, first_pulse, first_low, pulses;
  logic prev_t = 1'b0;
  logic q = 1'b0;
  logic hi_seen;

  task automatic model_edge(input logic b, input logic r, output logic pt, output logic pl);
    logic sv;
    pt = 1'b0;
    if (!r) begin
      m_sync = '0; m_run_val = 1'b0; m_run_len = 0; m_level = 1'b0; m_rep = 0;
    end else begin
      sv = m_sync[SYNC-1];
      m_sync = {m_sync[SYNC-2:0], b};
      if (sv == m_run_val) m_run_len++;
      else begin
        m_run_val = sv;
        m_run_len = 1;
      end
      if (m_run_len >= DEB && m_run_val != m_level) begin
        pt = m_run_val;
        m_level = m_run_val;
        m_rep = 0;
      end else if (m_level && sv && m_run_len >= 2) begin
`ifdef AUTO_REPEAT_EN
        m_rep++;
        if (m_rep == REP) begin
          pt = 1'b1;
          m_rep = 0;
        end
`endif
      end else begin
        m_rep = 0;
      end
    end
    pl = m_level;
  endtask

  task automatic step(input logic b, input logic r);
    logic pt, pl;
    logic [1:0] got;
    @(negedge clk);
    btn_in = b;
    reset  = r;
    model_edge(b, r, pt, pl);
    exp_q.push_back({pt, pl});
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("t_out", t_out, got[1]);
    check("btn_level", btn_level, got[0]);
    if (t_out === 1'b1) begin
      check("pulse_width", prev_t, 0);
      pulses++;
      if (first_pulse < 0) first_pulse = idx;
    end
    if (btn_level === 1'b0 && first_low < 0) first_low = idx;
    if (btn_level === 1'b1) hi_seen = 1'b1;
    q = q ^ t_out;
    prev_t = t_out;
    idx++;
  endtask

  task automatic start_phase();
    idx = 0; first_pulse = -1; first_low = -1; pulses = 0; hi_seen = 1'b0;
  endtask

  localparam logic [9:0] BOUNCE_PRESS   = 10'b1111101011; // idx0 is LSB: 1,1,0,1,0,1,1,1,1,1
  localparam logic [8:0] BOUNCE_RELEASE = 9'b000010010;   // idx0 is LSB: 0,1,0,0,1,0,0,0,0

  initial begin
    logic [9:0] bp;
    logic [8:0] br;
    bp = BOUNCE_PRESS;
    br = BOUNCE_RELEASE;
    start_phase();

    // 1: reset, clean press and release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    start_phase();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    check("t1_pulses", pulses, 1);
    check("t1_latency", first_pulse, 5);
    check("t1_level_held", btn_level, 1);
    start_phase();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check("t1_release_pulses", pulses, EXP_REL_PULSES);
    check("t1_fall_edge", first_low, 5);
    check("t1_tff_q", q, EXP_Q1);

    // 2: press bounce
    start_phase();
    for (int i = 0; i < 10; i++) step(bp[i], 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    check("t2_pulses", pulses, 1);
    check("t2_latency", first_pulse, 10);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    // 3: release bounce
    start_phase();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("t3_press_pulses", pulses, 1);
    start_phase();
    for (int i = 0; i < 9; i++) step(br[i], 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("t3_release_pulses", pulses, 0);
    check("t3_fall_edge", first_low, 10);

    // 4: reset during PRESS_WAIT, then button held across reset release
    start_phase();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("t4_rst_t_out", t_out, 0);
    check("t4_rst_level", btn_level, 0);
    start_phase();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("t4_pulses", pulses, 1);
    check("t4_latency", first_pulse, 5);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    // 5: long hold
    start_phase();
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
    check("t5_pulses", pulses, EXP_HOLD100);
    check("t5_first", first_pulse, 5);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

    // 6: single-cycle glitches every third cycle
    start_phase();
    for (int i = 0; i < 50; i++) step((i % 3) == 0, 1'b1);
    check("t6_pulses", pulses, 0);
    check("t6_level_seen", hi_seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
